// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: state encoding, HLT opcode
// and the default number of stages drained behind ID after a halt.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } pipe_state_t;

    localparam logic [3:0] OP_HLT          = 4'hF;
    localparam int         DRAIN_DEPTH_DEF = 3;
    localparam int         DRAIN_CNT_W     = 8;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register write-enable/flush sequencing with halt drain and
// saturating stall/flush/miss performance counters.
//
//   state  | meaning
//   RUN    | normal issue; hazards, branches, misses resolved by priority
//   DRAIN  | HLT seen in ID; fetch frozen while older stages retire
//   HALTED | pipeline empty, everything frozen until reset
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        fd_branchtaken,
    input  logic        fd_halt,
    input  logic        ic_miss,
    input  logic        dc_miss,
    output logic        pc_we,
    output logic        fd_we,
    output logic        fd_flush,
    output logic        dx_we,
    output logic        dx_flush,
    output logic        xm_we,
    output logic        mw_we,
    output logic        mw_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] miss_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_DEPTH);

    pipe_state_t            state, state_nxt;
    logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic                   stall_inc, flush_inc, miss_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_we         = 1'b0;
        fd_we         = 1'b0;
        fd_flush      = 1'b0;
        dx_we         = 1'b0;
        dx_flush      = 1'b0;
        xm_we         = 1'b0;
        mw_we         = 1'b0;
        mw_flush      = 1'b0;
        halted        = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        miss_inc      = 1'b0;

        if (rst) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            mw_flush = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (dc_miss) begin
                        mw_we    = 1'b1;
                        mw_flush = 1'b1;
                        miss_inc = 1'b1;
                    end else if (hz_stall) begin
                        // bubble enters EX while IF/ID holds the dependent instruction
                        dx_we     = 1'b1;
                        dx_flush  = 1'b1;
                        xm_we     = 1'b1;
                        mw_we     = 1'b1;
                        stall_inc = 1'b1;
                    end else if (fd_branchtaken) begin
                        // fetch is wrong-path, so a pending icache miss is irrelevant
                        pc_we     = 1'b1;
                        fd_we     = 1'b1;
                        fd_flush  = 1'b1;
                        dx_we     = 1'b1;
                        xm_we     = 1'b1;
                        mw_we     = 1'b1;
                        flush_inc = 1'b1;
                    end else if (fd_halt || ic_miss) begin
                        fd_we    = 1'b1;
                        fd_flush = 1'b1;
                        dx_we    = 1'b1;
                        xm_we    = 1'b1;
                        mw_we    = 1'b1;
                        if (fd_halt) begin
                            state_nxt     = ST_DRAIN;
                            drain_cnt_nxt = DRAIN_LOAD;
                        end else begin
                            miss_inc = 1'b1;
                        end
                    end else begin
                        pc_we = 1'b1;
                        fd_we = 1'b1;
                        dx_we = 1'b1;
                        xm_we = 1'b1;
                        mw_we = 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (dc_miss) begin
                        mw_we    = 1'b1;
                        mw_flush = 1'b1;
                        miss_inc = 1'b1;
                    end else begin
                        fd_we    = 1'b1;
                        fd_flush = 1'b1;
                        dx_we    = 1'b1;
                        xm_we    = 1'b1;
                        mw_we    = 1'b1;
                        if (drain_cnt <= DRAIN_CNT_W'(1)) begin
                            drain_cnt_nxt = '0;
                            state_nxt     = ST_HALTED;
                        end else begin
                            drain_cnt_nxt = drain_cnt - DRAIN_CNT_W'(1);
                        end
                    end
                end

                ST_HALTED: begin
                    halted = 1'b1;
                end

                default: begin
                    state_nxt     = ST_RUN;
                    drain_cnt_nxt = '0;
                end
            endcase
        end
    end

    sat_counter16 u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt));
    sat_counter16 u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt));
    sat_counter16 u_miss_cnt  (.clk(clk), .rst(rst), .inc(miss_inc),  .count(miss_cnt));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a table-driven reference model checked every cycle,
// plus literal checkpoints along a directed stimulus sequence.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hz_stall = 1'b0;
    logic        fd_branchtaken = 1'b0;
    logic        fd_halt = 1'b0;
    logic        ic_miss = 1'b0;
    logic        dc_miss = 1'b0;
    logic        pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, mw_flush, halted;
    logic [15:0] stall_cnt, flush_cnt, miss_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipeline_ctrl #(.DRAIN_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .hz_stall(hz_stall), .fd_branchtaken(fd_branchtaken),
        .fd_halt(fd_halt), .ic_miss(ic_miss), .dc_miss(dc_miss),
        .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .dx_we(dx_we),
        .dx_flush(dx_flush), .xm_we(xm_we), .mw_we(mw_we), .mw_flush(mw_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = running, 1 = draining, 2 = halted
    int m_mode  = 0;
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_miss  = 0;

    function automatic int sat_add(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Expected {pc,fd,fd_flush,dx,dx_flush,xm,mw,mw_flush,halted}
    function automatic logic [8:0] model_outs(input bit r, input int mode,
                                              input bit dc, input bit hz, input bit br,
                                              input bit hl, input bit ic);
        if (r)          return 9'b0_0_1_0_1_0_0_1_0;
        if (mode == 2)  return 9'b0_0_0_0_0_0_0_0_1;
        if (dc)         return 9'b0_0_0_0_0_0_1_1_0;
        if (mode == 1)  return 9'b0_1_1_1_0_1_1_0_0;
        if (hz)         return 9'b0_0_0_1_1_1_1_0_0;
        if (br)         return 9'b1_1_1_1_0_1_1_0_0;
        if (hl || ic)   return 9'b0_1_1_1_0_1_1_0_0;
        return 9'b1_1_0_1_0_1_1_0_0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0; m_miss = 0;
        end else if (m_mode == 0) begin
            if (dc_miss)              m_miss  = sat_add(m_miss);
            else if (hz_stall)        m_stall = sat_add(m_stall);
            else if (fd_branchtaken)  m_flush = sat_add(m_flush);
            else if (fd_halt) begin
                m_mode = 1;
                m_left = 3;
            end else if (ic_miss)     m_miss  = sat_add(m_miss);
        end else if (m_mode == 1) begin
            if (dc_miss) m_miss = sat_add(m_miss);
            else begin
                m_left = m_left - 1;
                if (m_left <= 0) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0]  exp_o;
        logic [47:0] exp_c;
        exp_o = model_outs(rst, m_mode, dc_miss, hz_stall, fd_branchtaken, fd_halt, ic_miss);
        exp_c = {16'(m_stall), 16'(m_flush), 16'(m_miss)};
        total_cnt++;
        if ({pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, mw_flush, halted} === exp_o)
            pass_cnt++;
        else
            $display("FAIL ctrl_outs t=%0t actual=%b required=%b", $time,
                     {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, mw_flush, halted}, exp_o);
        total_cnt++;
        if ({stall_cnt, flush_cnt, miss_cnt} === exp_c)
            pass_cnt++;
        else
            $display("FAIL counters t=%0t actual=%h/%h/%h required=%h/%h/%h", $time,
                     stall_cnt, flush_cnt, miss_cnt, exp_c[47:32], exp_c[31:16], exp_c[15:0]);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // inputs hold for one full cycle, then settle 1 time unit after the edge
    task automatic step(input bit r, input bit dc, input bit hz, input bit br,
                        input bit hl, input bit ic);
        rst = r; dc_miss = dc; hz_stall = hz; fd_branchtaken = br; fd_halt = hl; ic_miss = ic;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        check("idle_pc_we",   16'(pc_we),    16'd1);
        check("idle_fd_flush",16'(fd_flush), 16'd0);
        check("idle_halted",  16'(halted),   16'd0);
        check("idle_stall",   stall_cnt,     16'd0);

        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("hz2_stall_cnt", stall_cnt, 16'd2);

        step(0, 0, 0, 1, 0, 1);
        check("br_ic_flush_cnt", flush_cnt, 16'd1);
        check("br_ic_miss_cnt",  miss_cnt,  16'd0);

        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        check("dc_hz_miss_cnt",  miss_cnt,  16'd3);
        check("dc_hz_stall_cnt", stall_cnt, 16'd2);

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 1);
        check("mixed_flush_cnt", flush_cnt, 16'd2);
        check("mixed_miss_cnt",  miss_cnt,  16'd5);

        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("drain4_not_halted", 16'(halted), 16'd0);
        step(0, 0, 0, 0, 0, 0);
        check("halted_after5", 16'(halted), 16'd1);
        check("halted_mw_we",  16'(mw_we),  16'd0);
        check("drain_miss_cnt", miss_cnt, 16'd6);
        step(0, 0, 1, 1, 1, 1);
        check("halted_hold", 16'(halted), 16'd1);
        check("halted_flush_cnt", flush_cnt, 16'd2);

        step(1, 0, 0, 0, 0, 0);
        check("rst_from_halt_miss", miss_cnt, 16'd0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_mid_drain_pc_we", 16'(pc_we), 16'd1);
        check("rst_mid_drain_halted", 16'(halted), 16'd0);

        for (int i = 0; i < 65537; i++) step(0, 0, 1, 0, 0, 0);
        check("stall_saturated", stall_cnt, 16'hFFFF);
        step(1, 0, 0, 0, 0, 0);
        check("rst_clear_stall", stall_cnt, 16'd0);
        check("rst_clear_flush", flush_cnt, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        check("post_rst_pc_we", 16'(pc_we), 16'd1);
        step(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
